calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
Clocked command sequencer for the keypad calculator datapath. It owns the two-entry operand stack (A = queue[1], B = queue[0]) and decodes each keypad event. It drives the external adder through A/B and samples its result, and runs request/acknowledge transactions to the 10-entry register bank for store and load. Errors are handled in a sticky ERROR state that saturates the display operands.

Parameters:
WIDTH, 8, operand/register data width (two's complement)
NREGS, 10, number of register-bank entries; valid addresses 0..NREGS-1
ACK_TIMEOUT, 15, max cycles to wait for reg_ack before declaring error (4-bit counter)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state
tecla  in  4  key code, valid while ready falls
ready  in  1  key strobe from debouncer, synchronous to clk; falling edge = key event
calcresult  in  WIDTH  adder output, combinational A+B
overflow  in  1  adder signed-overflow flag for A+B
regload  in  WIDTH  register-bank read data, valid with reg_ack
reg_ack  in  1  register-bank acknowledge (single-cycle pulse)
regadress  out  4  register-bank address
regstore  out  WIDTH  register-bank write data
regwrite  out  1  write request, held until ack/timeout
regread  out  1  read request, held until ack/timeout
A  out  WIDTH  stack entry 1
B  out  WIDTH  stack entry 0 (display)
ok  out  1  1 = no error
key  out  1  error indicator (= ~ok)
busy  out  1  1 while a register transaction is in flight

Behaviour:
- Reset (async, reset=0): A=0, B=0, regadress=0, regstore=0, regwrite=0, regread=0, ok=1, key=0, busy=0, ready_q=1, timeout count=0, state=IDLE.
- Event detect: ready_q <= ready each edge. Event = ready_q & ~ready at the edge. One event per falling edge; a held-low ready produces no further events.
- States: IDLE, WR (store), RD (load), ERROR.
- IDLE, event, tecla executed at that edge (results visible next cycle):
  - 0000-1001: B <= zero-extended digit; A unchanged.
  - 1010 sum: overflow=1 -> ERROR; else B <= calcresult, A <= 0.
  - 1011 sub: C = ~B+1, S = A+C (mod 2^WIDTH). Overflow when A[MSB]==C[MSB] and S[MSB]!=A[MSB] -> ERROR. Else B <= S, A <= 0. Edge case B=0x80: C=0x80, rule applied as is.
  - 1100 store: B unsigned >= NREGS (covers negative B) -> ERROR. Else regadress <= B[3:0], regstore <= A, regwrite <= 1, busy <= 1, count <= 0 -> WR.
  - 1101 load: same range check. Else regadress <= B[3:0], regread <= 1, busy <= 1, count <= 0 -> RD.
  - 1110 enter: A <= B.
  - 1111: no operation.
- WR/RD, each edge:
  - reg_ack=1: drop request, busy <= 0 -> IDLE. In RD, also B <= regload, A unchanged.
  - Else count++. When count reaches ACK_TIMEOUT-1 without ack: drop request -> ERROR.
  - Key events arriving in WR/RD are discarded and never queued.
  - reg_ack in IDLE/ERROR is ignored.
- Entering ERROR: A <= 0x7F, B <= 0x7F, ok <= 0, key <= 1, regwrite/regread/busy <= 0.
- ERROR: holds. The next key event, whatever its code, is consumed only to clear: ok <= 1, key <= 0, A <= 0, B <= 0 -> IDLE. The key itself is not executed.
- Reset mid-transaction: requests drop asynchronously; no partial B update.
- regadress and regstore hold their last values outside transactions.

Test Plan:
- Reset, then keys 3, 1110, 4, 1010 (calcresult=7, overflow=0) -> A=0, B=7, ok=1; each update one cycle after the event edge.
- A=0x05, B=0x09, key 1011 -> B=0xFC, A=0. A=0x80, B=0x01, key 1011 -> ERROR: A=B=0x7F, ok=0, key=1. Any following key -> A=B=0, ok=1.
- A=0x2A, B=0x03, key 1100, ack after 3 cycles -> regwrite high exactly until the ack edge, regadress=3, regstore=0x2A, busy low after, A/B unchanged. Repeat with B=0x0A -> ERROR, regwrite never asserted.
- B=0x05, key 1101, reg_ack with regload=0x11 on cycle 2 -> B=0x11, regread dropped. Repeat with no ack -> ERROR after 15 cycles, regread low.
- Key event during RD plus ready held low 10 cycles -> event ignored, exactly one event total. Reset asserted mid-WR -> regwrite=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// Keypad/adder/register-bank signal bundle for calc_sequencer.
// The master side drives keys, adder results and bank responses.
// The slave side (the sequencer) drives stack, bank requests and status.
interface calc_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       tecla;
  logic             ready;
  logic [WIDTH-1:0] calcresult;
  logic             overflow;
  logic [WIDTH-1:0] regload;
  logic             reg_ack;
  logic [3:0]       regadress;
  logic [WIDTH-1:0] regstore;
  logic             regwrite;
  logic             regread;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ok;
  logic             key;
  logic             busy;

  modport master (
    output tecla, ready, calcresult, overflow, regload, reg_ack,
    input  regadress, regstore, regwrite, regread, A, B, ok, key, busy
  );

  modport slave (
    input  tecla, ready, calcresult, overflow, regload, reg_ack,
    output regadress, regstore, regwrite, regread, A, B, ok, key, busy
  );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad calculator command sequencer: owns the two-entry operand stack,
// decodes key events, samples the external adder and runs store/load
// handshakes to the register bank. Errors park in a sticky ERROR state
// with saturated operands until the next key clears it.
module calc_sequencer #(
  parameter int WIDTH       = 8,
  parameter int NREGS       = 10,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  calc_sequencer_if.slave bus
);

  localparam logic [3:0]       K_SUM     = 4'hA;
  localparam logic [3:0]       K_SUB     = 4'hB;
  localparam logic [3:0]       K_STORE   = 4'hC;
  localparam logic [3:0]       K_LOAD    = 4'hD;
  localparam logic [3:0]       K_ENTER   = 4'hE;
  localparam logic [3:0]       K_NOP     = 4'hF;
  localparam logic [WIDTH-1:0] SAT       = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NREGS_W   = WIDTH'(NREGS);
  localparam logic [3:0]       LAST_WAIT = 4'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WR, RD, ERROR} state_t;

  state_t           state, next_state;
  logic             ready_q;
  logic [3:0]       count;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       adr_q;
  logic [WIDTH-1:0] store_q;

  logic             key_event;
  logic [WIDTH-1:0] neg_b;
  logic [WIDTH-1:0] diff;
  logic             sub_ovf;
  logic             in_range;
  logic             timeout;

  // A key event is the falling edge of the debounced strobe.
  assign key_event = ready_q & ~bus.ready;
  // Subtraction as A + (~B + 1); overflow judged on the two's-complement
  // operands, so B = most-negative follows the same rule without a special case.
  assign neg_b     = ~b_q + WIDTH'(1);
  assign diff      = a_q + neg_b;
  assign sub_ovf   = (a_q[WIDTH-1] == neg_b[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
  // Unsigned compare also rejects negative addresses.
  assign in_range  = b_q < NREGS_W;
  assign timeout   = count == LAST_WAIT;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode from key events, bank acknowledge and timeout.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    next_state = state;
    unique case (state)
      IDLE: begin
        if (key_event) begin
          case (bus.tecla)
            K_SUM:   if (bus.overflow) next_state = ERROR;
            K_SUB:   if (sub_ovf) next_state = ERROR;
            K_STORE: next_state = in_range ? WR : ERROR;
            K_LOAD:  next_state = in_range ? RD : ERROR;
            default: next_state = IDLE;
          endcase
        end
      end
      WR, RD: begin
        if (bus.reg_ack)  next_state = IDLE;
        else if (timeout) next_state = ERROR;
      end
      ERROR:   if (key_event) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand stack, bank address/data and wait counter updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b1;
      count   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      adr_q   <= '0;
      store_q <= '0;
    end else begin
      ready_q <= bus.ready;
      if (next_state == ERROR && state != ERROR) begin
        a_q <= SAT;
        b_q <= SAT;
      end else begin
        case (state)
          IDLE: begin
            if (key_event) begin
              case (bus.tecla)
                K_SUM: begin
                  b_q <= bus.calcresult;
                  a_q <= '0;
                end
                K_SUB: begin
                  b_q <= diff;
                  a_q <= '0;
                end
                K_STORE: begin
                  adr_q   <= b_q[3:0];
                  store_q <= a_q;
                  count   <= '0;
                end
                K_LOAD: begin
                  adr_q <= b_q[3:0];
                  count <= '0;
                end
                K_ENTER: a_q <= b_q;
                K_NOP:   ;
                default: b_q <= {{(WIDTH-4){1'b0}}, bus.tecla};
              endcase
            end
          end
          WR, RD: begin
            if (bus.reg_ack) begin
              if (state == RD) b_q <= bus.regload;
            end else begin
              count <= count + 4'd1;
            end
          end
          ERROR: begin
            if (key_event) begin
              a_q <= '0;
              b_q <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs: requests and status follow the state, so reset drops them at once.
  always_comb begin
    bus.regwrite  = (state == WR);
    bus.regread   = (state == RD);
    bus.busy      = (state == WR) || (state == RD);
    bus.ok        = (state != ERROR);
    bus.key       = (state == ERROR);
    bus.regadress = adr_q;
    bus.regstore  = store_q;
    bus.A         = a_q;
    bus.B         = b_q;
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed key sequences, a behavioural model of
// the calculator compared on every falling clock edge, and literal checks.
module tb_calc_sequencer;

  localparam int W   = 8;
  localparam int NR  = 10;
  localparam int TMO = 15;

  localparam logic [3:0] K_SUM = 4'hA, K_SUB = 4'hB, K_STORE = 4'hC,
                         K_LOAD = 4'hD, K_ENTER = 4'hE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  calc_sequencer_if #(.WIDTH(W)) bus ();

  calc_sequencer #(.WIDTH(W), .NREGS(NR), .ACK_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_a = 0, m_b = 0, m_adr = 0, m_st = 0;
  bit         m_err = 0;
  int         m_pend = 0;   // 0 none, 1 store in flight, 2 load in flight
  int         m_wait = 0;   // cycles spent waiting for the bank
  bit         m_rq = 1;
  bit         m_evt;
  bit         m_ovf;
  int         sa, sb;

  task automatic m_error();
    m_a = 8'h7F; m_b = 8'h7F; m_err = 1; m_pend = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_adr = 0; m_st = 0; m_err = 0; m_pend = 0; m_wait = 0; m_rq = 1;
    end else begin
      m_evt = m_rq && !bus.ready;
      m_rq  = bus.ready;
      if (m_err) begin
        if (m_evt) begin m_err = 0; m_a = 0; m_b = 0; end
      end else if (m_pend != 0) begin
        if (bus.reg_ack) begin
          if (m_pend == 2) m_b = bus.regload;
          m_pend = 0;
        end else begin
          m_wait++;
          if (m_wait == TMO) m_error();
        end
      end else if (m_evt) begin
        if (bus.tecla <= 4'd9) m_b = {4'b0, bus.tecla};
        else if (bus.tecla == K_SUM) begin
          if (bus.overflow) m_error();
          else begin m_b = bus.calcresult; m_a = 0; end
        end else if (bus.tecla == K_SUB) begin
          sa = int'($signed(m_a));
          sb = int'($signed(m_b));
          // Negating the most-negative value wraps to itself; the rule then
          // flags overflow exactly when A is negative.
          if (m_b == 8'h80) m_ovf = m_a[7];
          else              m_ovf = (sa - sb > 127) || (sa - sb < -128);
          if (m_ovf) m_error();
          else begin m_b = 8'(sa - sb); m_a = 0; end
        end else if (bus.tecla == K_STORE || bus.tecla == K_LOAD) begin
          if (m_b >= 8'(NR)) m_error();
          else begin
            m_adr = {4'b0, m_b[3:0]};
            if (bus.tecla == K_STORE) begin m_st = m_a; m_pend = 1; end
            else m_pend = 2;
            m_wait = 0;
          end
        end else if (bus.tecla == K_ENTER) m_a = m_b;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    check("A",         32'(bus.A),         32'(m_a));
    check("B",         32'(bus.B),         32'(m_b));
    check("ok",        32'(bus.ok),        32'(!m_err));
    check("key",       32'(bus.key),       32'(m_err));
    check("busy",      32'(bus.busy),      32'(m_pend != 0));
    check("regwrite",  32'(bus.regwrite),  32'(m_pend == 1));
    check("regread",   32'(bus.regread),   32'(m_pend == 2));
    check("regadress", 32'(bus.regadress), 32'(m_adr[3:0]));
    check("regstore",  32'(bus.regstore),  32'(m_st));
  end

  // ---------------- stimulus helpers ----------------
  // One-cycle low pulse on ready; returns on the falling edge right after
  // the clock edge that executed the key.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.tecla = k;
    bus.ready = 1'b0;
    @(negedge clk);
    bus.ready = 1'b1;
  endtask

  task automatic give_ack(input int n, input logic [7:0] data);
    repeat (n) @(negedge clk);
    bus.regload = data;
    bus.reg_ack = 1'b1;
    @(negedge clk);
    bus.reg_ack = 1'b0;
  endtask

  // A <- a through the adder path, then B <- b through a load from entry 0.
  task automatic set_ab(input logic [7:0] a, input logic [7:0] b);
    bus.calcresult = a;
    bus.overflow   = 1'b0;
    press(K_SUM);
    press(K_ENTER);
    press(4'd0);
    press(K_LOAD);
    give_ack(1, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tecla = 4'hF; bus.ready = 1'b1; bus.calcresult = '0; bus.overflow = 1'b0;
    bus.regload = '0; bus.reg_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ok",  32'(bus.ok), 32'h1);
    check("reset B",   32'(bus.B),  32'h0);
    rst_n = 1'b1;

    // 3 ENTER 4 SUM with the adder reporting 7.
    press(4'd3);        check("digit B",  32'(bus.B), 32'h03);
    press(K_ENTER);     check("enter A",  32'(bus.A), 32'h03);
    press(4'd4);        check("digit2 B", 32'(bus.B), 32'h04);
    bus.calcresult = 8'h07; bus.overflow = 1'b0;
    press(K_SUM);
    check("sum B", 32'(bus.B), 32'h07);
    check("sum A", 32'(bus.A), 32'h00);
    check("model sum B", 32'(m_b), 32'h07);

    // Subtraction, normal and overflowing, then clear.
    set_ab(8'h05, 8'h09);
    press(K_SUB);
    check("sub B", 32'(bus.B), 32'hFC);
    check("model sub B", 32'(m_b), 32'hFC);
    set_ab(8'h80, 8'h01);
    press(K_SUB);
    check("sub ovf A",   32'(bus.A),   32'h7F);
    check("sub ovf B",   32'(bus.B),   32'h7F);
    check("sub ovf key", 32'(bus.key), 32'h1);
    press(4'd7);
    check("clear B",  32'(bus.B),  32'h00);
    check("clear ok", 32'(bus.ok), 32'h1);

    // B = 0x80 edge of the subtraction rule.
    set_ab(8'h00, 8'h80);
    press(K_SUB);       check("sub 0-80 B",  32'(bus.B),  32'h80);
    set_ab(8'hFF, 8'h80);
    press(K_SUB);       check("sub FF-80 ok", 32'(bus.ok), 32'h0);
    press(4'd1);

    // Adder overflow.
    bus.calcresult = 8'h80; bus.overflow = 1'b1;
    press(K_SUM);       check("sum ovf ok", 32'(bus.ok), 32'h0);
    press(4'd1);
    bus.overflow = 1'b0;

    // Store with ack three cycles in.
    set_ab(8'h2A, 8'h03);
    press(K_STORE);
    check("store regwrite", 32'(bus.regwrite),  32'h1);
    check("store adr",      32'(bus.regadress), 32'h3);
    check("store data",     32'(bus.regstore),  32'h2A);
    give_ack(2, 8'h00);
    check("store done busy", 32'(bus.busy),     32'h0);
    check("store done rw",   32'(bus.regwrite), 32'h0);
    check("store keeps A",   32'(bus.A),        32'h2A);
    set_ab(8'h2A, 8'h0A);
    press(K_STORE);
    check("store range ok", 32'(bus.ok),       32'h0);
    check("store range rw", 32'(bus.regwrite), 32'h0);
    give_ack(0, 8'h55);
    check("ack in error ignored", 32'(bus.B), 32'h7F);
    press(4'd0);

    // Load with ack, then load that times out.
    press(4'd5);
    press(K_LOAD);
    give_ack(1, 8'h11);
    check("load B",  32'(bus.B),       32'h11);
    check("load rr", 32'(bus.regread), 32'h0);
    press(4'd5);
    press(K_LOAD);
    repeat (TMO - 1) @(negedge clk);
    check("load still waiting", 32'(bus.regread), 32'h1);
    @(negedge clk);
    check("timeout rr", 32'(bus.regread), 32'h0);
    check("timeout ok", 32'(bus.ok),      32'h0);
    press(4'd9);

    // Stray ack while idle.
    press(4'd2);
    give_ack(0, 8'h66);
    check("idle ack ignored", 32'(bus.B), 32'h02);

    // Key event during a load, with ready then held low for ten cycles.
    press(4'd5);
    press(K_LOAD);
    @(negedge clk);
    bus.tecla = 4'd1;
    bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    bus.regload = 8'h22;
    bus.reg_ack = 1'b1;
    @(negedge clk);
    bus.reg_ack = 1'b0;
    repeat (6) @(negedge clk);
    bus.ready = 1'b1;
    @(negedge clk);
    check("discarded key B", 32'(bus.B),  32'h22);
    check("discarded key ok", 32'(bus.ok), 32'h1);

    // Reset asserted in the middle of a store.
    set_ab(8'h33, 8'h04);
    press(K_STORE);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst regwrite", 32'(bus.regwrite),  32'h0);
    check("rst busy",     32'(bus.busy),      32'h0);
    check("rst A",        32'(bus.A),         32'h00);
    check("rst B",        32'(bus.B),         32'h00);
    check("rst adr",      32'(bus.regadress), 32'h0);
    check("rst data",     32'(bus.regstore),  32'h00);
    check("rst ok",       32'(bus.ok),        32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    press(4'd8);
    check("after rst B", 32'(bus.B), 32'h08);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
